// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXE/MEM/WB over a shared-memory datapath,
// stalls on MIO_ready and traps on undecodable instructions or memory accesses that never complete.
module mcpu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1),
    parameter bit RESET_PC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemRW,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [2:0] ImmSel,
    output logic [3:0] ALU_Control,
    output logic       CPU_MIO,
    output logic [3:0] state,
    output logic       illegal_inst,
    output logic       mem_timeout
);
    typedef enum logic [3:0] {
        S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXE_R = 4'd3,
        S_EXE_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
        S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
        S_LUI = 4'd12, S_AUIPC = 4'd13, S_ALU_WB = 4'd14, S_TRAP = 4'd15
    } state_t;

    localparam state_t RESET_STATE = RESET_PC_EN ? S_INIT : S_FETCH;

    localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1100, ALU_OR = 4'b0001, ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b1110, ALU_SRL = 4'b1101, ALU_SRA = 4'b1111;
    localparam logic [2:0] IMM_U = 3'b000, IMM_I = 3'b001, IMM_S = 3'b010, IMM_B = 3'b011, IMM_J = 3'b100;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic            illegal_q, illegal_d, timeout_q, timeout_d;
    logic            timeout_hit, br_taken;
    logic [4:0]      r_dec, i_dec;
    logic            unused_opc_lsbs;

    // {legal, alu_op} for register-register encodings.
    function automatic logic [4:0] r_alu(input logic [2:0] f3, input logic f7);
        logic [4:0] r;
        case ({f7, f3})
            4'b0_000: r = {1'b1, ALU_ADD};
            4'b1_000: r = {1'b1, ALU_SUB};
            4'b0_001: r = {1'b1, ALU_SLL};
            4'b0_010: r = {1'b1, ALU_SLT};
            4'b0_011: r = {1'b1, ALU_SLTU};
            4'b0_100: r = {1'b1, ALU_XOR};
            4'b0_101: r = {1'b1, ALU_SRL};
            4'b1_101: r = {1'b1, ALU_SRA};
            4'b0_110: r = {1'b1, ALU_OR};
            4'b0_111: r = {1'b1, ALU_AND};
            default:  r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

    // Immediate forms: Fun7 is an immediate bit except for the shift encodings.
    function automatic logic [4:0] i_alu(input logic [2:0] f3, input logic f7);
        logic [4:0] r;
        case (f3)
            3'b000:  r = {1'b1, ALU_ADD};
            3'b001:  r = {~f7, f7 ? ALU_ADD : ALU_SLL};
            3'b010:  r = {1'b1, ALU_SLT};
            3'b011:  r = {1'b1, ALU_SLTU};
            3'b100:  r = {1'b1, ALU_XOR};
            3'b101:  r = {1'b1, f7 ? ALU_SRA : ALU_SRL};
            3'b110:  r = {1'b1, ALU_OR};
            default: r = {1'b1, ALU_AND};
        endcase
        return r;
    endfunction

    assign r_dec           = r_alu(Fun3, Fun7);
    assign i_dec           = i_alu(Fun3, Fun7);
    assign wait_inc        = (wait_cnt_q >= TO_W'(MEM_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + TO_W'(1);
    assign timeout_hit     = (wait_inc == TO_W'(MEM_TIMEOUT));
    assign br_taken        = Fun3[0] ^ (Fun3[2] ? ~zero : zero);
    assign unused_opc_lsbs = &OPcode[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        PCWrite     = 1'b0;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemRW       = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 2'b00;
        ALUSrc_A    = 2'b00;
        ALUSrc_B    = 2'b00;
        ImmSel      = IMM_U;
        ALU_Control = ALU_ADD;
        case (state_q)
            S_INIT: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrc_B = 2'b01;
                if (MIO_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (timeout_hit) begin
                        state_d   = S_TRAP;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut from the old PC.
                ALUSrc_A = 2'b10;
                ALUSrc_B = 2'b10;
                ImmSel   = IMM_B;
                case (OPcode[6:2])
                    5'b01100:          state_d = S_EXE_R;
                    5'b00100:          state_d = S_EXE_I;
                    5'b00000, 5'b01000: state_d = S_MEM_ADDR;
                    5'b11000:          state_d = S_BRANCH;
                    5'b11011:          state_d = S_JAL;
                    5'b11001:          state_d = S_JALR;
                    5'b01101:          state_d = S_LUI;
                    5'b00101:          state_d = S_AUIPC;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXE_R, S_EXE_I: begin
                ALUSrc_A = 2'b01;
                if (state_q == S_EXE_I) begin
                    ALUSrc_B = 2'b10;
                    ImmSel   = IMM_I;
                end
                if ((state_q == S_EXE_R) ? r_dec[4] : i_dec[4]) begin
                    ALU_Control = (state_q == S_EXE_R) ? r_dec[3:0] : i_dec[3:0];
                    state_d     = S_ALU_WB;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                ALUSrc_A = 2'b01;
                ALUSrc_B = 2'b10;
                ImmSel   = OPcode[5] ? IMM_S : IMM_I;
                state_d  = OPcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                IorD    = 1'b1;
                MemRead = (state_q == S_MEM_RD);
                MemRW   = (state_q == S_MEM_WR);
                if (MIO_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (timeout_hit) begin
                        state_d   = S_TRAP;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrc_A = 2'b01;
                PCSrc    = 2'b01;
                case (Fun3[2:1])
                    2'b00:   ALU_Control = ALU_SUB;
                    2'b10:   ALU_Control = ALU_SLT;
                    2'b11:   ALU_Control = ALU_SLTU;
                    default: ALU_Control = ALU_ADD;
                endcase
                if (Fun3[2:1] == 2'b01) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    PCWrite = br_taken;
                    state_d = S_FETCH;
                end
            end
            S_JAL, S_JALR: begin
                // Link value comes from the PC register before this cycle's update.
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                ALUSrc_A = (state_q == S_JAL) ? 2'b10 : 2'b01;
                ALUSrc_B = 2'b10;
                ImmSel   = (state_q == S_JAL) ? IMM_J : IMM_I;
                PCWrite  = 1'b1;
                PCSrc    = (state_q == S_JAL) ? 2'b00 : 2'b10;
                state_d  = S_FETCH;
            end
            S_LUI: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b11;
                state_d  = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrc_A = 2'b10;
                ALUSrc_B = 2'b10;
                state_d  = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                wait_cnt_d = wait_cnt_q;
            end
        endcase
        // While reset is held the bus and PC stay quiet, even in the reset-vector state.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCSrc       = 2'b00;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemRW       = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemtoReg    = 2'b00;
            ALUSrc_A    = 2'b00;
            ALUSrc_B    = 2'b00;
            ImmSel      = IMM_U;
            ALU_Control = ALU_ADD;
        end
    end

    assign CPU_MIO      = MemRead | MemRW;
    assign state        = state_q;
    assign illegal_inst = illegal_q;
    assign mem_timeout  = timeout_q;
endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: decode vector table, hand-written corner sequences and random
// instruction streams checked cycle by cycle against an instruction-level reference model.
module tb_mcpu_ctrl_fsm;
    localparam int MEM_TIMEOUT = 16;

    localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXE_R = 4'd3;
    localparam logic [3:0] S_EXE_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7;
    localparam logic [3:0] S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11;
    localparam logic [3:0] S_LUI = 4'd12, S_AUIPC = 4'd13, S_ALU_WB = 4'd14, S_TRAP = 4'd15;
    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_SLT = 4'b0111, A_SLTU = 4'b1001;
    localparam logic [3:0] A_XOR = 4'b1100, A_OR = 4'b0001, A_AND = 4'b0000;
    localparam logic [3:0] A_SLL = 4'b1110, A_SRL = 4'b1101, A_SRA = 4'b1111;

    logic       clk = 1'b0;
    logic       rst_n, Fun7, zero, MIO_ready;
    logic [6:0] OPcode;
    logic [2:0] Fun3;
    logic       PCWrite, IorD, MemRead, MemRW, IRWrite, RegWrite, CPU_MIO, illegal_inst, mem_timeout;
    logic [1:0] PCSrc, MemtoReg, ALUSrc_A, ALUSrc_B;
    logic [2:0] ImmSel;
    logic [3:0] ALU_Control, state;

    always #5 clk = ~clk;

    mcpu_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .RESET_PC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7), .zero(zero),
        .MIO_ready(MIO_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead),
        .MemRW(MemRW), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ImmSel(ImmSel), .ALU_Control(ALU_Control),
        .CPU_MIO(CPU_MIO), .state(state), .illegal_inst(illegal_inst), .mem_timeout(mem_timeout)
    );

    typedef struct packed {
        logic [3:0] st;  logic pcw; logic [1:0] pcsrc; logic iord; logic mr; logic mw; logic irw;
        logic rw; logic [1:0] m2r; logic [1:0] a; logic [1:0] b; logic [2:0] imm; logic [3:0] alu;
        logic mio; logic ill; logic to;
    } ctrl_t;
    typedef struct { logic rdy; logic z; ctrl_t exp; } cyc_t;
    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic f7; logic z;
        logic [3:0] st; logic [3:0] alu; logic pcw; logic [3:0] nxt;
    } vec_t;

    cyc_t q[$];
    vec_t vt[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic ctrl_t base(input logic [3:0] st);
        ctrl_t c;
        c = '0;
        c.st = st;
        c.alu = A_ADD;
        return c;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t c;
        c.st = state; c.pcw = PCWrite; c.pcsrc = PCSrc; c.iord = IorD; c.mr = MemRead;
        c.mw = MemRW; c.irw = IRWrite; c.rw = RegWrite; c.m2r = MemtoReg; c.a = ALUSrc_A;
        c.b = ALUSrc_B; c.imm = ImmSel; c.alu = ALU_Control; c.mio = CPU_MIO;
        c.ill = illegal_inst; c.to = mem_timeout;
        return c;
    endfunction

    task automatic check_word(input string name, input ctrl_t exp);
        ctrl_t act;
        act = sample();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got state=%0d ctrl=%h, expected state=%0d ctrl=%h", name, act.st, act, exp.st, exp);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic void push(input logic rdy, input logic z, input ctrl_t exp);
        cyc_t c;
        c.rdy = rdy;
        c.z = z;
        c.exp = exp;
        c.exp.mio = exp.mr | exp.mw;
        q.push_back(c);
    endfunction

    function automatic void push_trap(input logic ill, input logic to);
        ctrl_t w;
        for (int i = 0; i < 3; i++) begin
            w = base(S_TRAP);
            w.ill = ill;
            w.to = to;
            push(rb(), rb(), w);
        end
    endfunction

    // A memory access answered on wait cycle d; ready never arriving within MEM_TIMEOUT cycles traps.
    function automatic bit push_access(input ctrl_t wait_w, input ctrl_t done_w, input int d);
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            if (k == d) begin
                push(1'b1, rb(), done_w);
                return 1'b1;
            end
            push(1'b0, rb(), wait_w);
        end
        push_trap(1'b0, 1'b1);
        return 1'b0;
    endfunction

    // Reference ALU op for register or immediate arithmetic; bit 4 marks a legal encoding.
    function automatic logic [4:0] ref_alu(input bit imm_form, input logic [2:0] f3, input logic f7);
        logic [4:0] r;
        bit plain;
        plain = imm_form || !f7;
        case (f3)
            3'b000:  r = {1'b1, (imm_form || !f7) ? A_ADD : A_SUB};
            3'b001:  r = f7 ? {1'b0, A_ADD} : {1'b1, A_SLL};
            3'b010:  r = {plain, plain ? A_SLT : A_ADD};
            3'b011:  r = {plain, plain ? A_SLTU : A_ADD};
            3'b100:  r = {plain, plain ? A_XOR : A_ADD};
            3'b101:  r = {1'b1, f7 ? A_SRA : A_SRL};
            3'b110:  r = {plain, plain ? A_OR : A_ADD};
            default: r = {plain, plain ? A_AND : A_ADD};
        endcase
        return r;
    endfunction

    // Expands one instruction into its expected per-cycle control trace; returns 1 if it ends in TRAP.
    function automatic bit model_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                       input int fd, input int md);
        ctrl_t w, d;
        logic [4:0] alu5;
        logic [3:0] balu;
        logic z;
        bit taken, legal;
        w = base(S_FETCH); w.mr = 1'b1; w.b = 2'b01;
        d = w; d.irw = 1'b1; d.pcw = 1'b1;
        if (!push_access(w, d, fd)) return 1'b1;
        w = base(S_DECODE); w.a = 2'b10; w.b = 2'b10; w.imm = 3'b011;
        push(rb(), rb(), w);
        case (op[6:2])
            5'b01100, 5'b00100: begin
                alu5 = ref_alu(!op[5], f3, f7);
                w = base(op[5] ? S_EXE_R : S_EXE_I); w.a = 2'b01;
                if (!op[5]) begin w.b = 2'b10; w.imm = 3'b001; end
                if (alu5[4]) w.alu = alu5[3:0];
                push(rb(), rb(), w);
                if (!alu5[4]) begin push_trap(1'b1, 1'b0); return 1'b1; end
                w = base(S_ALU_WB); w.rw = 1'b1; push(rb(), rb(), w);
            end
            5'b00000, 5'b01000: begin
                w = base(S_MEM_ADDR); w.a = 2'b01; w.b = 2'b10; w.imm = op[5] ? 3'b010 : 3'b001;
                push(rb(), rb(), w);
                if (op[5]) begin
                    w = base(S_MEM_WR); w.mw = 1'b1; w.iord = 1'b1;
                    if (!push_access(w, w, md)) return 1'b1;
                end else begin
                    w = base(S_MEM_RD); w.mr = 1'b1; w.iord = 1'b1;
                    if (!push_access(w, w, md)) return 1'b1;
                    w = base(S_MEM_WB); w.rw = 1'b1; w.m2r = 2'b01; push(rb(), rb(), w);
                end
            end
            5'b11000: begin
                z = rb(); legal = 1'b1; taken = 1'b0; balu = A_ADD;
                case (f3)
                    3'b000:  begin taken = z;  balu = A_SUB;  end
                    3'b001:  begin taken = !z; balu = A_SUB;  end
                    3'b100:  begin taken = !z; balu = A_SLT;  end
                    3'b101:  begin taken = z;  balu = A_SLT;  end
                    3'b110:  begin taken = !z; balu = A_SLTU; end
                    3'b111:  begin taken = z;  balu = A_SLTU; end
                    default: legal = 1'b0;
                endcase
                w = base(S_BRANCH); w.a = 2'b01; w.pcsrc = 2'b01; w.alu = balu; w.pcw = legal && taken;
                push(rb(), z, w);
                if (!legal) begin push_trap(1'b1, 1'b0); return 1'b1; end
            end
            5'b11011: begin
                w = base(S_JAL); w.rw = 1'b1; w.m2r = 2'b10; w.a = 2'b10; w.b = 2'b10;
                w.imm = 3'b100; w.pcw = 1'b1; push(rb(), rb(), w);
            end
            5'b11001: begin
                w = base(S_JALR); w.rw = 1'b1; w.m2r = 2'b10; w.a = 2'b01; w.b = 2'b10;
                w.imm = 3'b001; w.pcw = 1'b1; w.pcsrc = 2'b10; push(rb(), rb(), w);
            end
            5'b01101: begin
                w = base(S_LUI); w.rw = 1'b1; w.m2r = 2'b11; push(rb(), rb(), w);
            end
            5'b00101: begin
                w = base(S_AUIPC); w.a = 2'b10; w.b = 2'b10; push(rb(), rb(), w);
                w = base(S_ALU_WB); w.rw = 1'b1; push(rb(), rb(), w);
            end
            default: begin
                push_trap(1'b1, 1'b0);
                return 1'b1;
            end
        endcase
        return 1'b0;
    endfunction

    task automatic run_queue(input string tag);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            MIO_ready = c.rdy;
            zero = c.z;
            @(negedge clk);
            check_word(tag, c.exp);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        ctrl_t w;
        rst_n = 1'b0; MIO_ready = 1'b0; zero = 1'b0;
        @(negedge clk);
        check_word("reset_hold", base(S_INIT));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        w = base(S_INIT); w.pcw = 1'b1; w.pcsrc = 2'b11;
        check_word("init_reset_vector", w);
        @(posedge clk); #1;
    endtask

    task automatic run_one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int fd, input int md, output bit trapped);
        OPcode = op; Fun3 = f3; Fun7 = f7;
        trapped = model_instr(op, f3, f7, fd, md);
        run_queue(tag);
    endtask

    initial begin
        forever begin
            #1000000;
            $display("FAIL watchdog: simulation time limit reached, expected completion");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        bit trapped;
        logic [6:0] op;
        logic [6:0] ops [9];
        vec_t v;
        rst_n = 1'b0; OPcode = 7'h00; Fun3 = 3'b000; Fun7 = 1'b0; zero = 1'b0; MIO_ready = 1'b0;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        // op, f3, f7, zero, execute state, ALU_Control there, PCWrite there, following state
        vt.push_back('{7'h33, 3'b000, 1'b0, 1'b0, S_EXE_R,  A_ADD,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b000, 1'b1, 1'b0, S_EXE_R,  A_SUB,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b001, 1'b0, 1'b0, S_EXE_R,  A_SLL,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b010, 1'b0, 1'b0, S_EXE_R,  A_SLT,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b011, 1'b0, 1'b0, S_EXE_R,  A_SLTU, 1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b100, 1'b0, 1'b0, S_EXE_R,  A_XOR,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b101, 1'b0, 1'b0, S_EXE_R,  A_SRL,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b101, 1'b1, 1'b0, S_EXE_R,  A_SRA,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b110, 1'b0, 1'b0, S_EXE_R,  A_OR,   1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b111, 1'b0, 1'b0, S_EXE_R,  A_AND,  1'b0, S_ALU_WB});
        vt.push_back('{7'h33, 3'b001, 1'b1, 1'b0, S_EXE_R,  A_ADD,  1'b0, S_TRAP});
        vt.push_back('{7'h13, 3'b000, 1'b1, 1'b0, S_EXE_I,  A_ADD,  1'b0, S_ALU_WB});
        vt.push_back('{7'h13, 3'b101, 1'b1, 1'b0, S_EXE_I,  A_SRA,  1'b0, S_ALU_WB});
        vt.push_back('{7'h13, 3'b001, 1'b1, 1'b0, S_EXE_I,  A_ADD,  1'b0, S_TRAP});
        vt.push_back('{7'h63, 3'b000, 1'b0, 1'b1, S_BRANCH, A_SUB,  1'b1, S_FETCH});
        vt.push_back('{7'h63, 3'b001, 1'b0, 1'b1, S_BRANCH, A_SUB,  1'b0, S_FETCH});
        vt.push_back('{7'h63, 3'b100, 1'b0, 1'b0, S_BRANCH, A_SLT,  1'b1, S_FETCH});
        vt.push_back('{7'h63, 3'b101, 1'b0, 1'b1, S_BRANCH, A_SLT,  1'b1, S_FETCH});
        vt.push_back('{7'h63, 3'b101, 1'b0, 1'b0, S_BRANCH, A_SLT,  1'b0, S_FETCH});
        vt.push_back('{7'h63, 3'b110, 1'b0, 1'b0, S_BRANCH, A_SLTU, 1'b1, S_FETCH});
        vt.push_back('{7'h63, 3'b010, 1'b0, 1'b0, S_BRANCH, A_ADD,  1'b0, S_TRAP});
        vt.push_back('{7'h67, 3'b000, 1'b0, 1'b0, S_JALR,   A_ADD,  1'b1, S_FETCH});
        vt.push_back('{7'h37, 3'b000, 1'b0, 1'b0, S_LUI,    A_ADD,  1'b0, S_FETCH});
        vt.push_back('{7'h7F, 3'b000, 1'b0, 1'b0, S_TRAP,   A_ADD,  1'b0, S_TRAP});

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            do_reset();
            OPcode = v.op; Fun3 = v.f3; Fun7 = v.f7; zero = v.z; MIO_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            @(negedge clk);
            check_val($sformatf("vec%0d_exec", i), 32'({state, ALU_Control, PCWrite}), 32'({v.st, v.alu, v.pcw}));
            @(posedge clk); #1;
            check_val($sformatf("vec%0d_next", i), 32'(state), 32'(v.nxt));
        end

        // add x3,x1,x2 (0x002081B3) with memory always ready
        do_reset();
        run_one("add", 7'h33, 3'b000, 1'b0, 0, 0, trapped);
        MIO_ready = 1'b0;
        @(negedge clk);
        check_val("add_back_to_fetch", 32'(state), 32'(S_FETCH));

        // lw (0x0000A183) with three not-ready cycles in MEM_RD
        do_reset();
        run_one("lw_wait3", 7'h03, 3'b010, 1'b0, 0, 3, trapped);

        // fetch that never completes, then one answered on the last allowed cycle
        do_reset();
        run_one("fetch_timeout", 7'h33, 3'b000, 1'b0, 16, 0, trapped);
        check_val("fetch_timeout_trapped", 32'(trapped), 32'd1);
        do_reset();
        run_one("fetch_ready_last", 7'h33, 3'b000, 1'b0, 15, 0, trapped);
        do_reset();
        run_one("load_timeout", 7'h03, 3'b010, 1'b0, 0, 16, trapped);

        // undecodable opcode sits in TRAP with strobes low
        do_reset();
        run_one("illegal_7f", 7'h7F, 3'b000, 1'b0, 0, 0, trapped);

        // reset asserted in the middle of a store
        do_reset();
        OPcode = 7'h23; Fun3 = 3'b010; Fun7 = 1'b0; MIO_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        MIO_ready = 1'b0;
        @(posedge clk); #1;
        check_val("sw_in_mem_wr", 32'({state, MemRW, IorD, CPU_MIO}), 32'({S_MEM_WR, 1'b1, 1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check_val("sw_reset_drops_memrw", 32'({state, MemRW, CPU_MIO, PCWrite}), 32'({S_INIT, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("sw_init_once", 32'({state, PCWrite, PCSrc}), 32'({S_INIT, 1'b1, 2'b11}));
        @(posedge clk); #1;
        check_val("sw_then_fetch", 32'({state, PCWrite, MemRead}), 32'({S_FETCH, 1'b0, 1'b1}));

        // random instruction stream
        do_reset();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 8)];
            run_one("random", op, 3'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 39) == 0) ? 16 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 39) == 0) ? 16 : int'($urandom_range(0, 3)), trapped);
            if (trapped) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
